// File: rtl/mul_seq_pkg.sv
// Shared definitions for the nibble-serial multiplier: state encoding,
// nibble width and the default operand width.
package mul_seq_pkg;

    localparam int NIB_W     = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_mul_sequencer_mul4.sv
// four_bit_multiplier: combinational 4x4 unsigned multiplier that forms one
// 8-bit partial product per cycle for the nibble sequencer.
module four_bit_multiplier (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    // Zero-extend both nibbles so the product is computed at its full 8 bits.
    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/nibble_mul_sequencer.sv
// nibble_mul_sequencer: multi-cycle unsigned WIDTH x WIDTH multiplier that
// walks every nibble pair of the operands through one 4x4 multiplier,
// one pair per cycle, accumulating shifted partial products.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: when defined, a zero operand
// at the handshake skips CALC and produces a zero result immediately.
module nibble_mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;
    logic [CW-1:0]        r_i;
    logic [CW-1:0]        r_j;

    logic [NIB_W-1:0]     w_nib_a;
    logic [NIB_W-1:0]     w_nib_b;
    logic [2*NIB_W-1:0]   w_p;
    logic [31:0]          w_shamt;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;
    logic                 w_last;
    logic                 w_skip;

    // Nibble i of A and nibble j of B feed the shared 4x4 multiplier.
    assign w_nib_a = r_a[NIB_W*r_i +: NIB_W];
    assign w_nib_b = r_b[NIB_W*r_j +: NIB_W];

    four_bit_multiplier u_mul4 (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_p)
    );

    // The partial product carries weight 16^(i+j); the sum cannot overflow
    // because the accumulator is a full 2*WIDTH bits wide.
    assign w_shamt = NIB_W * (32'(r_i) + 32'(r_j));
    assign w_pp    = {{(2*WIDTH-2*NIB_W){1'b0}}, w_p} << w_shamt;
    assign w_sum   = r_acc + w_pp;
    assign w_last  = (r_i == CW'(NIB-1)) && (r_j == CW'(NIB-1));

`ifdef MUL_SEQ_ZERO_SKIP_EN
    assign w_skip = (a == '0) || (b == '0);
`else
    assign w_skip = 1'b0;
`endif

    assign result = r_result;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; no overlap between result and new operands.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = w_skip ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, nibble counters (j fastest) and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_i      <= '0;
            r_j      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                        if (w_skip) begin
                            r_result <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_result <= w_sum;
                        r_i      <= '0;
                        r_j      <= '0;
                    end else if (r_j == CW'(NIB-1)) begin
                        r_j <= '0;
                        r_i <= r_i + CW'(1);
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
